alu_muldiv: RTL and testbench

Parametrised, handshaked execution unit for the RISC-V core: the successor to the single-cycle ALU. It executes all RV32I/RV64I integer ALU, compare and branch-condition operations in one registered cycle, and adds the M extension (MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU) as an iterative multi-cycle engine. It sits between decode/register read and writeback. The core stalls on `in_ready` and consumes results through `out_valid`/`out_ready`. Register-file storage stays outside this block.

---
 rtl/exec_pkg.sv | 35 +++
 rtl/muldiv_iter.sv | 139 +++++++++++++
 rtl/alu_muldiv.sv | 111 +++++++++++
 tb/tb_alu_muldiv.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/exec_pkg.sv
// rtl/exec_pkg.sv - operation codes, engine states and decode helpers for alu_muldiv
package exec_pkg;

  typedef enum logic [4:0] {
    OP_ADD, OP_SUB, OP_XOR, OP_OR, OP_AND,
    OP_SLL, OP_SRL, OP_SRA,
    OP_SLT, OP_SLTU, OP_LT, OP_LTU, OP_GE, OP_GEU, OP_EQ, OP_NE,
    OP_PASSB, OP_AUIPC, OP_LINK,
    OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU,
    OP_DIV, OP_DIVU, OP_REM, OP_REMU
  } alu_op_e;

  typedef enum logic [1:0] {
    IDLE,
    MUL,
    DIV
  } state_e;

  function automatic logic is_muldiv(input logic [4:0] op);
    return (op >= OP_MUL) && (op <= OP_REMU);
  endfunction

  function automatic logic is_div(input logic [4:0] op);
    return (op >= OP_DIV) && (op <= OP_REMU);
  endfunction

  function automatic logic is_signed_a(input logic [4:0] op);
    return (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
  endfunction

  function automatic logic is_signed_b(input logic [4:0] op);
    return (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
  endfunction

endpackage

// File: rtl/muldiv_iter.sv
// rtl/muldiv_iter.sv - iterative shift-add multiplier / restoring divider on operand magnitudes,
// with single-cycle resolution of divide-by-zero and signed-overflow cases.
module muldiv_iter
  import exec_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush_i,
  input  logic            start_i,
  input  logic [4:0]      op_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  output logic            special_o,
  output logic [XLEN-1:0] special_res_o,
  output logic            busy_o,
  output logic            done_o,
  output logic [XLEN-1:0] res_o
);

  localparam int CNT_W = $clog2(XLEN);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN - 1);

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [2*XLEN-1:0]   acc_q, acc_d, acc_step;
  logic [XLEN-1:0]     opnd_q, opnd_d;
  logic [4:0]          op_q, op_d;
  logic                qneg_q, qneg_d, rneg_q, rneg_d;

  logic                sa, sb, b_zero, ovf;
  logic [XLEN-1:0]     mag_a, mag_b;
  logic [XLEN:0]       mul_sum, div_part;
  logic                div_ge;
  logic [XLEN-1:0]     div_sub, quo, rem;
  logic [2*XLEN-1:0]   prod;

  assign b_zero = (b_i == '0);
  assign ovf    = ((op_i == OP_DIV) || (op_i == OP_REM)) &&
                  (a_i == {1'b1, {(XLEN-1){1'b0}}}) && (&b_i);
  assign special_o = is_div(op_i) && (b_zero || ovf);

  always_comb begin
    special_res_o = '0;
    if (b_zero) begin
      special_res_o = ((op_i == OP_DIV) || (op_i == OP_DIVU)) ? '1 : a_i;
    end else if (op_i == OP_DIV) begin
      special_res_o = a_i;
    end
  end

  assign sa    = is_signed_a(op_i) && a_i[XLEN-1];
  assign sb    = is_signed_b(op_i) && b_i[XLEN-1];
  assign mag_a = sa ? -a_i : a_i;
  assign mag_b = sb ? -b_i : b_i;

  // Multiply: acc = {partial product, remaining multiplier}; divide: acc = {remainder, quotient}.
  always_comb begin
    mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    div_part = acc_q[2*XLEN-1:XLEN-1];
    div_ge   = (div_part >= {1'b0, opnd_q});
    div_sub  = div_part[XLEN-1:0] - opnd_q;
    if (state_q == MUL) begin
      acc_step = {mul_sum, acc_q[XLEN-1:1]};
    end else if (div_ge) begin
      acc_step = {div_sub, acc_q[XLEN-2:0], 1'b1};
    end else begin
      acc_step = {acc_q[2*XLEN-2:0], 1'b0};
    end
  end

  always_comb begin
    prod = qneg_q ? -acc_step : acc_step;
    quo  = qneg_q ? -acc_step[XLEN-1:0] : acc_step[XLEN-1:0];
    rem  = rneg_q ? -acc_step[2*XLEN-1:XLEN] : acc_step[2*XLEN-1:XLEN];
    case (op_q)
      OP_MUL:                         res_o = prod[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU:   res_o = prod[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:                res_o = quo;
      default:                        res_o = rem;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    opnd_d  = opnd_q;
    op_d    = op_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    if (flush_i) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else if (state_q == IDLE) begin
      if (start_i) begin
        state_d = is_div(op_i) ? DIV : MUL;
        cnt_d   = CNT_LAST;
        acc_d   = {{XLEN{1'b0}}, mag_a};
        opnd_d  = mag_b;
        op_d    = op_i;
        qneg_d  = sa ^ sb;
        rneg_d  = sa;
      end
    end else begin
      acc_d = acc_step;
      if (cnt_q == '0) begin
        state_d = IDLE;
      end else begin
        cnt_d = cnt_q - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      opnd_q  <= '0;
      op_q    <= '0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      opnd_q  <= opnd_d;
      op_q    <= op_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
    end
  end

  assign busy_o = (state_q != IDLE);
  assign done_o = busy_o && (cnt_q == '0);

endmodule

// File: rtl/alu_muldiv.sv
// rtl/alu_muldiv.sv - handshaked RV32/RV64 execution unit: single-cycle ALU plus iterative M extension.
module alu_muldiv
  import exec_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int SHAMT_W = $clog2(XLEN)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [4:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic [XLEN-1:0] pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            busy
);

  logic               ready_q;
  logic               out_valid_q, out_valid_d;
  logic [XLEN-1:0]    result_q, result_d, alu_res;
  logic               accept, start, special, mdu_busy, mdu_done;
  logic [XLEN-1:0]    special_res, mdu_res;
  logic [SHAMT_W-1:0] shamt;
  logic               lt_s, lt_u;

  // ready_q keeps in_ready low for the first cycle after reset release.
  assign in_ready = rst_n && ready_q && !mdu_busy && (!out_valid_q || out_ready);
  assign accept   = in_valid && in_ready && !flush;
  assign start    = accept && is_muldiv(op) && !special;

  assign shamt = b[SHAMT_W-1:0];
  assign lt_s  = ($signed(a) < $signed(b));
  assign lt_u  = (a < b);

  always_comb begin
    alu_res = '0;
    case (op)
      OP_ADD:        alu_res = a + b;
      OP_SUB:        alu_res = a - b;
      OP_XOR:        alu_res = a ^ b;
      OP_OR:         alu_res = a | b;
      OP_AND:        alu_res = a & b;
      OP_SLL:        alu_res = a << shamt;
      OP_SRL:        alu_res = a >> shamt;
      OP_SRA:        alu_res = $signed(a) >>> shamt;
      OP_SLT, OP_LT: alu_res = XLEN'(lt_s);
      OP_SLTU, OP_LTU: alu_res = XLEN'(lt_u);
      OP_GE:         alu_res = XLEN'(!lt_s);
      OP_GEU:        alu_res = XLEN'(!lt_u);
      OP_EQ:         alu_res = XLEN'(a == b);
      OP_NE:         alu_res = XLEN'(a != b);
      OP_PASSB:      alu_res = b;
      OP_AUIPC:      alu_res = pc + b;
      OP_LINK:       alu_res = pc + XLEN'(4);
      default:       alu_res = '0;
    endcase
  end

  muldiv_iter #(.XLEN(XLEN)) u_iter (
    .clk           (clk),
    .rst_n         (rst_n),
    .flush_i       (flush),
    .start_i       (start),
    .op_i          (op),
    .a_i           (a),
    .b_i           (b),
    .special_o     (special),
    .special_res_o (special_res),
    .busy_o        (mdu_busy),
    .done_o        (mdu_done),
    .res_o         (mdu_res)
  );

  always_comb begin
    out_valid_d = out_valid_q;
    result_d    = result_q;
    if (flush) begin
      out_valid_d = 1'b0;
    end else if (accept && !start) begin
      out_valid_d = 1'b1;
      result_d    = is_muldiv(op) ? special_res : alu_res;
    end else if (mdu_done) begin
      out_valid_d = 1'b1;
      result_d    = mdu_res;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ready_q     <= 1'b0;
      out_valid_q <= 1'b0;
      result_q    <= '0;
    end else begin
      ready_q     <= 1'b1;
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
    end
  end

  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign busy      = mdu_busy;

endmodule

// File: tb/tb_alu_muldiv.sv
// tb/tb_alu_muldiv.sv - directed self-checking bench for alu_muldiv (XLEN=32 and XLEN=64 builds)
module tb_alu_muldiv;
  import exec_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, flush, in_valid, in_ready, out_valid, out_ready, busy;
  logic [4:0]  op;
  logic [31:0] a, b, pc, result;

  logic        in_valid_w, in_ready_w, out_valid_w, busy_w;
  logic [4:0]  op_w;
  logic [63:0] a_w, b_w, result_w;
  logic [63:0] pc_w = 64'h0;
  logic        out_ready_w = 1'b1;

  int n_tests = 0;
  int n_fail  = 0;

  alu_muldiv #(.XLEN(32)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .a(a), .b(b), .pc(pc), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .busy(busy)
  );

  alu_muldiv #(.XLEN(64)) dut_w (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid_w), .in_ready(in_ready_w),
    .op(op_w), .a(a_w), .b(b_w), .pc(pc_w), .out_valid(out_valid_w), .out_ready(out_ready_w),
    .result(result_w), .busy(busy_w)
  );

  typedef struct {
    logic [4:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Presents one op for one edge, then scrambles operands to prove they were captured.
  task automatic send(input logic [4:0] o, input logic [31:0] x, input logic [31:0] y);
    op = o; a = x; b = y; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; op = OP_ADD; a = 32'hDEAD_BEEF; b = 32'h0;
  endtask

  task automatic wait_valid(output int lat);
    lat = 1;
    while (out_valid !== 1'b1 && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  int lat;
  int seen;

  initial begin
    vecs.push_back('{OP_ADD,    32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1});
    vecs.push_back('{OP_SUB,    32'h0000_0005, 32'h0000_0007, 32'hFFFF_FFFE, 1});
    vecs.push_back('{OP_AND,    32'h0000_F0F0, 32'h0000_FF00, 32'h0000_F000, 1});
    vecs.push_back('{OP_XOR,    32'h0000_F0F0, 32'h0000_FF00, 32'h0000_0FF0, 1});
    vecs.push_back('{OP_SRA,    32'h8000_0000, 32'h0000_0004, 32'hF800_0000, 1});
    vecs.push_back('{OP_SRL,    32'h8000_0000, 32'h0000_0004, 32'h0800_0000, 1});
    vecs.push_back('{OP_SLL,    32'h0000_0001, 32'h0000_0021, 32'h0000_0002, 1});
    vecs.push_back('{OP_SLT,    32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 1});
    vecs.push_back('{OP_SLTU,   32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1});
    vecs.push_back('{OP_GEU,    32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 1});
    vecs.push_back('{OP_GE,     32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1});
    vecs.push_back('{OP_EQ,     32'h0000_0005, 32'h0000_0005, 32'h0000_0001, 1});
    vecs.push_back('{OP_NE,     32'h0000_0005, 32'h0000_0005, 32'h0000_0000, 1});
    vecs.push_back('{OP_PASSB,  32'h0000_0000, 32'hABCD_0000, 32'hABCD_0000, 1});
    vecs.push_back('{OP_AUIPC,  32'h0000_0000, 32'h0000_2000, 32'h0000_3000, 1});
    vecs.push_back('{OP_LINK,   32'h0000_0000, 32'h0000_0000, 32'h0000_1004, 1});
    vecs.push_back('{5'd31,     32'h0000_0005, 32'h0000_0006, 32'h0000_0000, 1});
    vecs.push_back('{OP_MUL,    32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 33});
    vecs.push_back('{OP_MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 33});
    vecs.push_back('{OP_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33});
    vecs.push_back('{OP_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33});
    vecs.push_back('{OP_DIV,    32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, 33});
    vecs.push_back('{OP_REM,    32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 33});
    vecs.push_back('{OP_DIVU,   32'h0000_0064, 32'h0000_0007, 32'h0000_000E, 33});
    vecs.push_back('{OP_REMU,   32'h0000_0064, 32'h0000_0007, 32'h0000_0002, 33});
    vecs.push_back('{OP_DIVU,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 33});
    vecs.push_back('{OP_DIVU,   32'h0000_0005, 32'h0000_0000, 32'hFFFF_FFFF, 1});
    vecs.push_back('{OP_REM,    32'h0000_0005, 32'h0000_0000, 32'h0000_0005, 1});
    vecs.push_back('{OP_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1});
    vecs.push_back('{OP_REM,    32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1});

    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    op = OP_ADD; a = '0; b = '0; pc = 32'h0000_1000;
    in_valid_w = 1'b0; op_w = OP_ADD; a_w = '0; b_w = '0;

    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", {63'd0, in_ready}, 64'd0);
    check("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("rst_result", {32'd0, result}, 64'd0);
    check("rst_busy", {63'd0, busy}, 64'd0);
    rst_n = 1'b1;
    #1;
    check("release_in_ready", {63'd0, in_ready}, 64'd0);
    @(posedge clk); #1;
    check("post_rst_in_ready", {63'd0, in_ready}, 64'd1);
    check("post_rst_in_ready_w", {63'd0, in_ready_w}, 64'd1);

    foreach (vecs[i]) begin
      send(vecs[i].op, vecs[i].a, vecs[i].b);
      if (vecs[i].lat > 1) check($sformatf("v%0d_busy", i), {63'd0, busy}, 64'd1);
      wait_valid(lat);
      check($sformatf("v%0d_op%0d_lat", i, vecs[i].op), 64'(lat), 64'(vecs[i].lat));
      check($sformatf("v%0d_op%0d_res", i, vecs[i].op), {32'd0, result}, {32'd0, vecs[i].exp});
      if (vecs[i].lat > 1) check($sformatf("v%0d_busy_fall", i), {63'd0, busy}, 64'd0);
    end

    // Backpressure: result must hold while the next op waits.
    @(posedge clk); #1;
    out_ready = 1'b0;
    send(OP_ADD, 32'h10, 32'h20);
    check("bp_first_valid", {63'd0, out_valid}, 64'd1);
    op = OP_SUB; a = 32'd9; b = 32'd4; in_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      check($sformatf("bp%0d_valid", c), {63'd0, out_valid}, 64'd1);
      check($sformatf("bp%0d_result", c), {32'd0, result}, 64'h30);
      check($sformatf("bp%0d_in_ready", c), {63'd0, in_ready}, 64'd0);
    end
    out_ready = 1'b1;
    #1;
    check("bp_release_in_ready", {63'd0, in_ready}, 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("bp_next_valid", {63'd0, out_valid}, 64'd1);
    check("bp_next_result", {32'd0, result}, 64'd5);

    // Flush mid-divide at T+10.
    @(posedge clk); #1;
    send(OP_DIVU, 32'd100, 32'd7);
    repeat (9) @(posedge clk);
    #1;
    check("fl_busy_before", {63'd0, busy}, 64'd1);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check("fl_busy_after", {63'd0, busy}, 64'd0);
    check("fl_out_valid", {63'd0, out_valid}, 64'd0);
    check("fl_in_ready", {63'd0, in_ready}, 64'd1);
    seen = 0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk); #1;
      if (out_valid === 1'b1) seen++;
    end
    check("fl_no_result", 64'(seen), 64'd0);
    send(OP_ADD, 32'd2, 32'd3);
    wait_valid(lat);
    check("fl_add_lat", 64'(lat), 64'd1);
    check("fl_add_res", {32'd0, result}, 64'd5);

    // Flush wins over a simultaneous acceptance.
    @(posedge clk); #1;
    op = OP_ADD; a = 32'd1; b = 32'd1; in_valid = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; flush = 1'b0;
    check("fl_prio_valid", {63'd0, out_valid}, 64'd0);
    check("fl_prio_busy", {63'd0, busy}, 64'd0);

    // XLEN=64 build.
    op_w = OP_MULHU; a_w = '1; b_w = '1; in_valid_w = 1'b1;
    @(posedge clk); #1;
    in_valid_w = 1'b0; a_w = '0; b_w = '0;
    check("w_busy", {63'd0, busy_w}, 64'd1);
    lat = 1;
    while (out_valid_w !== 1'b1 && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    check("w_mulhu_lat", 64'(lat), 64'd65);
    check("w_mulhu_res", result_w, 64'hFFFF_FFFF_FFFF_FFFE);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
